// File: rtl/key_repeat_ctrl_if.sv
// Key-side and pulse-side signals of key_repeat_ctrl.
// The master drives the raw keys; the slave (the controller) drives pulses and levels.
interface key_repeat_ctrl_if;
  logic key1;
  logic key2;
  logic inc_pulse;
  logic dec_pulse;
  logic key1_level;
  logic key2_level;
  logic repeat_active;

  modport master (
    output key1, key2,
    input  inc_pulse, dec_pulse, key1_level, key2_level, repeat_active
  );

  modport slave (
    input  key1, key2,
    output inc_pulse, dec_pulse, key1_level, key2_level, repeat_active
  );
endinterface

// File: rtl/key_repeat_ctrl.sv
// Two-key conditioner: synchronise, debounce, then emit inc/dec pulses
// with auto-repeat while a single key is held.
//
// state  | meaning
// IDLE   | no key owns the press; waiting for a debounced press
// DELAY  | first pulse issued; counting down to the first repeat
// REPEAT | issuing repeat pulses every REPEAT_PERIOD cycles
// LOCK   | both keys seen; silent until both are released
module key_repeat_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  key_repeat_ctrl_if.slave bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;

  localparam logic [DB_W-1:0] DB_TC    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_TC = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] PER_TC   = TM_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCK} state_t;

  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_level;
  logic [DB_W-1:0] r_db_cnt [2];

  state_t          r_state;
  state_t          w_next;
  logic            r_dir;
  logic            w_dir_next;
  logic [TM_W-1:0] r_timer;
  logic [TM_W-1:0] w_timer_next;
  logic            w_inc;
  logic            w_dec;
  logic            w_own;
  logic            w_other;
  logic [TM_W-1:0] w_tc;
  logic            r_inc_pulse;
  logic            r_dec_pulse;
  logic            r_repeat_active;

  // Keys are active-low; the synchronisers idle at 1 (released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_level <= '0;
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= {bus.key2, bus.key1};
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (~r_sync2[k] != r_level[k]) begin
          if (r_db_cnt[k] == DB_TC) begin
            r_level[k]  <= ~r_sync2[k];
            r_db_cnt[k] <= '0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
          end
        end else begin
          r_db_cnt[k] <= '0;
        end
      end
    end
  end

  // r_dir = 0 means key1 (inc) owns the press, 1 means key2 (dec).
  assign w_own   = r_dir ? r_level[1] : r_level[0];
  assign w_other = r_dir ? r_level[0] : r_level[1];
  assign w_tc    = (r_state == S_DELAY) ? DELAY_TC : PER_TC;

  always_comb begin
    w_next       = r_state;
    w_dir_next   = r_dir;
    w_timer_next = r_timer;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level[0] && r_level[1]) begin
          w_next = S_LOCK;
        end else if (r_level[0]) begin
          w_inc        = 1'b1;
          w_dir_next   = 1'b0;
          w_timer_next = '0;
          w_next       = S_DELAY;
        end else if (r_level[1]) begin
          w_dec        = 1'b1;
          w_dir_next   = 1'b1;
          w_timer_next = '0;
          w_next       = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        // Release wins over a same-cycle expiry, so the last pulse is suppressed.
        if (!w_own) begin
          w_next = S_IDLE;
        end else if (w_other) begin
          w_next = S_LOCK;
        end else if (r_timer == w_tc) begin
          w_inc        = ~r_dir;
          w_dec        = r_dir;
          w_timer_next = '0;
          w_next       = S_REPEAT;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_LOCK: begin
        if (!r_level[0] && !r_level[1]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_dir           <= 1'b0;
      r_timer         <= '0;
      r_inc_pulse     <= 1'b0;
      r_dec_pulse     <= 1'b0;
      r_repeat_active <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_dir           <= w_dir_next;
      r_timer         <= w_timer_next;
      r_inc_pulse     <= w_inc;
      r_dec_pulse     <= w_dec;
      r_repeat_active <= (w_next == S_REPEAT);
    end
  end

  assign bus.inc_pulse     = r_inc_pulse;
  assign bus.dec_pulse     = r_dec_pulse;
  assign bus.key1_level    = r_level[0];
  assign bus.key2_level    = r_level[1];
  assign bus.repeat_active = r_repeat_active;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Bench for key_repeat_ctrl: directed scenarios plus random key activity,
// compared every cycle against a press-age reference model.
module tb_key_repeat_ctrl;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk;
  logic rst_n;
  logic key1;
  logic key2;
  int   checks;
  int   failures;

  key_repeat_ctrl_if bus ();
  assign bus.key1 = key1;
  assign bus.key2 = key2;

  key_repeat_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: raw samples delayed two edges, debounced level follows
  // a value seen unchanged for D cycles; a held press has an age counted from
  // its first pulse, and pulses fire at age RD, RD+RP, RD+2RP, ...
  logic m_raw_d1 [2];
  logic m_raw_d2 [2];
  logic m_lvl    [2];
  int   m_run    [2];
  int   m_mode;   // 0 free, 1 held, 2 locked
  int   m_owner;  // 0 key1, 1 key2
  int   m_age;
  logic m_inc, m_dec, m_rep;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_raw_d1[k] = 1'b1;
      m_raw_d2[k] = 1'b1;
      m_lvl[k]    = 1'b0;
      m_run[k]    = 0;
    end
    m_mode = 0; m_owner = 0; m_age = 0;
    m_inc = 0; m_dec = 0; m_rep = 0;
  endfunction

  function automatic void model_step(logic raw1, logic raw2);
    logic ol [2];
    logic pulse;
    ol[0] = m_lvl[0];
    ol[1] = m_lvl[1];
    for (int k = 0; k < 2; k++) begin
      if (!m_raw_d2[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          m_lvl[k] = !m_raw_d2[k];
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_raw_d2[0] = m_raw_d1[0]; m_raw_d2[1] = m_raw_d1[1];
    m_raw_d1[0] = raw1;        m_raw_d1[1] = raw2;

    pulse = 1'b0;
    case (m_mode)
      0: begin
        if (ol[0] && ol[1]) m_mode = 2;
        else if (ol[0] || ol[1]) begin
          m_mode = 1; m_owner = ol[0] ? 0 : 1; m_age = 0; pulse = 1'b1;
        end
      end
      1: begin
        if (!ol[m_owner]) m_mode = 0;
        else if (ol[1 - m_owner]) m_mode = 2;
        else begin
          m_age++;
          if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) pulse = 1'b1;
        end
      end
      default: if (!ol[0] && !ol[1]) m_mode = 0;
    endcase
    m_inc = pulse && (m_owner == 0);
    m_dec = pulse && (m_owner == 1);
    m_rep = (m_mode == 1) && (m_age >= RD);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0b expected=%0b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("inc_pulse",     bus.inc_pulse,     m_inc);
    check("dec_pulse",     bus.dec_pulse,     m_dec);
    check("key1_level",    bus.key1_level,    m_lvl[0]);
    check("key2_level",    bus.key2_level,    m_lvl[1]);
    check("repeat_active", bus.repeat_active, m_rep);
    check("pulse_excl",    bus.inc_pulse & bus.dec_pulse, 1'b0);
  endtask

  task automatic tick();
    logic r1, r2;
    r1 = key1;
    r2 = key2;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(r1, r2);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset asserted between edges: outputs must clear before any clock.
  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    ticks(2);
    rst_n = 1'b1;
  endtask

  int first_inc_edge;

  initial begin
    checks = 0;
    failures = 0;
    key1 = 1'b1;
    key2 = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    ticks(3);
    rst_n = 1'b1;
    ticks(3);

    // Glitch shorter than the debounce window.
    key1 = 1'b0; ticks(3);
    key1 = 1'b1; ticks(10);

    // key1 held long enough for several repeats; first pulse after edge 7.
    key1 = 1'b0;
    first_inc_edge = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (first_inc_edge == 0 && bus.inc_pulse) first_inc_edge = e;
    end
    check("first_inc_edge", (first_inc_edge == 7), 1'b1);
    key1 = 1'b1; ticks(12);

    // key2 short hold around the first-repeat boundary.
    key2 = 1'b0; ticks(12);
    key2 = 1'b1; ticks(12);

    // Simultaneous press locks, then a fresh key2 press works again.
    key1 = 1'b0; key2 = 1'b0; ticks(20);
    key1 = 1'b1; ticks(20);
    key2 = 1'b1; ticks(10);
    key2 = 1'b0; ticks(10);
    key2 = 1'b1; ticks(12);

    // Second key interrupts an auto-repeat.
    key1 = 1'b0; ticks(22);
    key2 = 1'b0; ticks(12);
    key1 = 1'b1; key2 = 1'b1; ticks(12);

    // Reset in REPEAT with key1 still held.
    key1 = 1'b0; ticks(20);
    reset_mid();
    ticks(12);
    key1 = 1'b1; ticks(12);

    // Random key activity with occasional resets.
    for (int s = 0; s < 80; s++) begin
      key1 = 1'($urandom_range(0, 1));
      key2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ticks($urandom_range(1, 4));
      else ticks($urandom_range(1, 35));
      if ($urandom_range(0, 19) == 0) reset_mid();
    end
    key1 = 1'b1; key2 = 1'b1; ticks(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
